// File: rtl/mul8_arbiter.sv
// Round-robin arbiter sharing one 8x8 array multiplier among NREQ requesters.
// Define MUL8_ARB_FAST_EN to skip the operand-register stage (latency 1).
module mul8_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [8*NREQ-1:0]    req_a,
    input  logic [8*NREQ-1:0]    req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [15:0]          rsp_data,
    output logic [IDW-1:0]       rsp_id
);

    // Handshakes: a transfer happens at a posedge where valid and ready are both 1.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [7:0]     op_a_q, op_a_d;
    logic [7:0]     op_b_q, op_b_d;
    logic [IDW-1:0] id_q, id_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [15:0]    rsp_data_q, rsp_data_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;

    logic           grant_found;
    logic [IDW-1:0] grant_idx;
    logic           accept;
    logic [7:0]     sel_a;
    logic [7:0]     sel_b;

    // Shift-and-add array of partial products, unsigned 8x8 -> 16.
    function automatic logic [15:0] mul_8array(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] acc;
        acc = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc + ({8'd0, a} << i);
        end
        return acc;
    endfunction

    always_comb begin : arb
        logic [IDW-1:0] cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(rr_ptr_q) + k) % NREQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign accept    = (state_q == IDLE) && rst_n && grant_found;
    assign req_ready = accept ? (NREQ'(1) << grant_idx) : '0;
    assign sel_a     = req_a[8*grant_idx +: 8];
    assign sel_b     = req_b[8*grant_idx +: 8];

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_a_d   = sel_a;
                    op_b_d   = sel_b;
                    id_d     = grant_idx;
                    rr_ptr_d = grant_idx;
`ifdef MUL8_ARB_FAST_EN
                    rsp_data_d  = mul_8array(sel_a, sel_b);
                    rsp_id_d    = grant_idx;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
`else
                    state_d  = CALC;
`endif
                end
            end
            CALC: begin
                rsp_data_d  = mul_8array(op_a_q, op_b_q);
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= IDW'(NREQ - 1);
            op_a_q      <= '0;
            op_b_q      <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_mul8_arbiter.sv
// Bench for mul8_arbiter: directed scenarios plus random traffic against a
// transaction-level model of the arbiter (rotation pointer, latency countdown).
module tb_mul8_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
`ifdef MUL8_ARB_FAST_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic                 clk;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [8*NREQ-1:0]    req_a;
    logic [8*NREQ-1:0]    req_b;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [15:0]          rsp_data;
    logic [IDW-1:0]       rsp_id;

    mul8_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: who was granted last, whether a transaction is in flight, and its result.
    int          m_last = NREQ - 1;
    bit          m_busy = 0;
    bit          m_rv   = 0;
    int          m_cnt  = 0;
    logic [15:0] m_data = '0;
    int          m_id   = 0;

    logic [NREQ-1:0] obs_ready;
    logic            obs_valid;
    logic            obs_rsp;
    logic [15:0]     obs_data;
    logic [IDW-1:0]  obs_id;

    logic [15:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_grant();
        if (!rst_n || m_busy) return -1;
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (m_last + k) % NREQ;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    // One clock cycle: check outputs mid-cycle, advance the model at the edge.
    task automatic step();
        int g;
        logic [NREQ-1:0] exp_ready;
        @(negedge clk);
        g = exp_grant();
        exp_ready = (g >= 0) ? (NREQ'(1) << g) : '0;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("rsp_valid", 32'(rsp_valid), 32'(m_rv));
        if (m_rv) begin
            check("rsp_data", 32'(rsp_data), 32'(m_data));
            check("rsp_id", 32'(rsp_id), 32'(m_id));
        end
        obs_ready = req_ready;
        obs_valid = rsp_valid;
        obs_rsp   = rsp_valid && rsp_ready;
        obs_data  = rsp_data;
        obs_id    = rsp_id;
        @(posedge clk);
        if (!rst_n) begin
            m_busy = 0; m_rv = 0; m_last = NREQ - 1; m_data = '0; m_id = 0;
        end else if (g >= 0) begin
            m_busy = 1;
            m_id   = g;
            m_last = g;
            m_data = 16'(int'(req_a[8*g +: 8]) * int'(req_b[8*g +: 8]));
            m_cnt  = LAT - 1;
            if (m_cnt == 0) m_rv = 1;
        end else if (m_busy && !m_rv) begin
            m_cnt--;
            if (m_cnt == 0) m_rv = 1;
        end else if (m_rv && rsp_ready) begin
            m_rv   = 0;
            m_busy = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rst_rsp_data", 32'(rsp_data), 32'(0));
        check("rst_rsp_id", 32'(rsp_id), 32'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int grant_at;
        int got_g[$];
        int exp_g[$];
        int cnt;
        bit done;
        logic [15:0]    held_data;
        logic [IDW-1:0] held_id;

        rst_n = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        @(posedge clk); #1;

        // Single request, ff*de.
        do_reset();
        req_valid = 4'b0001; req_a = 32'h0000_00ff; req_b = 32'h0000_00de; rsp_ready = 1'b1;
        grant_at = -1; done = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            step();
            if (obs_ready != 0) begin
                check("single_grant", 32'(obs_ready), 32'h1);
                grant_at  = i;
                req_valid = '0;
            end
            if (obs_rsp) begin
                check("single_data", 32'(obs_data), 32'hdd22);
                check("single_id", 32'(obs_id), 32'h0);
                check("single_latency", 32'(i - grant_at), 32'(LAT));
                done = 1;
            end
        end
        check("single_timeout", 32'(done), 32'h1);

        // Round robin with all requesters valid.
        do_reset();
        req_a = {8'h00, 8'h80, 8'h10, 8'h03};
        req_b = {8'hff, 8'h80, 8'h10, 8'h05};
        req_valid = 4'b1111; rsp_ready = 1'b1;
        exp_q = '{16'h000f, 16'h0100, 16'h4000, 16'h0000, 16'h000f};
        exp_g = '{0, 1, 2, 3, 0};
        got_g = '{};
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
            step();
            if (obs_ready != 0) got_g.push_back(onehot_idx(obs_ready));
            if (obs_rsp) check("rr_data", 32'(obs_data), 32'(exp_q.pop_front()));
        end
        check("rr_resp_count", 32'(exp_q.size()), 32'h0);
        check("rr_grant_count", 32'(got_g.size() >= 5), 32'h1);
        for (int i = 0; i < 5 && i < got_g.size(); i++) check("rr_grant", 32'(got_g[i]), 32'(exp_g[i]));

        // Backpressure: response held for 5 cycles.
        do_reset();
        req_valid = 4'b0001; req_a = 32'h0000_0037; req_b = 32'h0000_00c5; rsp_ready = 1'b0;
        done = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            step();
            if (obs_valid) done = 1;
        end
        check("bp_timeout", 32'(done), 32'h1);
        req_valid = 4'b1111;
        held_data = obs_data; held_id = obs_id;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_valid", 32'(obs_valid), 32'h1);
            check("bp_data", 32'(obs_data), 32'(held_data));
            check("bp_id", 32'(obs_id), 32'(held_id));
            check("bp_ready", 32'(obs_ready), 32'h0);
        end
        check("bp_product", 32'(held_data), 32'(16'h0037 * 16'h00c5));
        rsp_ready = 1'b1;
        step();
        step();
        check("bp_back_idle", 32'(obs_ready != 0), 32'h1);

        // Reset while CALC (or RESP in the fast build) is in progress.
        do_reset();
        req_valid = 4'b0001; req_a = 32'h0000_0099; req_b = 32'h0000_0077; rsp_ready = 1'b1;
        step();
        check("midrst_grant", 32'(obs_ready), 32'h1);
        req_valid = '0; rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("midrst_no_rsp", 32'(obs_valid), 32'h0);
        end
        req_valid = 4'b1010;
        step();
        check("midrst_next_grant", 32'(obs_ready), 32'h2);

        // Only requester 2 active: must be served every time.
        do_reset();
        req_valid = 4'b0100; rsp_ready = 1'b1; cnt = 0;
        for (int i = 0; i < 30; i++) begin
            req_a[23:16] = 8'($urandom); req_b[23:16] = 8'($urandom);
            step();
            if (obs_ready == 4'b0100) cnt++;
            if (obs_rsp) check("sparse_id", 32'(obs_id), 32'h2);
        end
        check("sparse_grants", 32'(cnt), 32'((30 + LAT) / (LAT + 1)));

        // Random traffic with occasional resets.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            req_valid = NREQ'($urandom_range(0, 15));
            req_a     = $urandom;
            req_b     = $urandom;
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst_n     = ($urandom_range(0, 60) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
